// File: rtl/gpio_bidir_pio_if.sv
// -----------------------------------------------------------------------------
// gpio_bidir_pio_if
//   Avalon-MM slave bus bundle for the gpio_bidir_pio block.
//
//   Signals:
//     address     3-bit register select
//     chipselect  Avalon chipselect
//     write_n     Avalon write strobe, active-low
//     writedata   32-bit write data
//     readdata    32-bit registered read data (slave output)
//     irq         level interrupt, active-high (slave output)
//
//   Modports:
//     master  drives the request side, receives readdata/irq
//     slave   receives the request side, drives readdata/irq
// -----------------------------------------------------------------------------
interface gpio_bidir_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/gpio_bidir_pio.sv
// -----------------------------------------------------------------------------
// gpio_bidir_pio
//   Parametrised bidirectional PIO: WIDTH tri-state pins with per-bit
//   direction, 2-flop input synchroniser, per-bit edge capture, interrupt
//   mask and a registered level interrupt. Avalon-MM slave, 1-cycle read
//   latency (readdata is re-registered from the address every cycle).
//
//   Parameters:
//     WIDTH      number of port bits (1..32)
//     EDGE_TYPE  captured edge: 0 rising, 1 falling, 2 any
//     RESET_OUT  reset value of data_out
//     RESET_DIR  reset value of data_dir (1 = drive)
//
//   Ports:
//     clk         system clock
//     reset_n     synchronous active-low reset
//     avs         Avalon-MM slave bundle (gpio_bidir_pio_if.slave)
//     bidir_port  WIDTH tri-state pins
//
//   Register map (address):
//     0 DATA     read synchronised pins, write data_out
//     1 DIR      read/write data_dir
//     2 IRQMASK  read/write irq_mask
//     3 EDGECAP  read edge_capture, write 1 to clear
//     4 OUTSET   (GPIO_PIO_BITSET_EN) data_out |= wd, reads data_out
//     5 OUTCLR   (GPIO_PIO_BITSET_EN) data_out &= ~wd, reads data_out
//     6,7        read 0, writes ignored (also 4,5 without the macro)
//
//   Optional feature macro: GPIO_PIO_BITSET_EN
// -----------------------------------------------------------------------------
module gpio_bidir_pio #(
  parameter int               WIDTH     = 8,
  parameter int               EDGE_TYPE = 0,
  parameter logic [WIDTH-1:0] RESET_OUT = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RESET_DIR = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  gpio_bidir_pio_if.slave   avs,
  inout  wire  [WIDTH-1:0]  bidir_port
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef GPIO_PIO_BITSET_EN
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

  // Architectural registers
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] data_dir_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_cap_r;

  // Input synchroniser and edge history
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] last_r;

  // Registered outputs
  logic [31:0]      readdata_r;
  logic             irq_r;

  // Combinational helpers
  logic             wr_en_s;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] data_out_nxt_s;
  logic [WIDTH-1:0] data_dir_nxt_s;
  logic [WIDTH-1:0] irq_mask_nxt_s;
  logic [WIDTH-1:0] edge_cap_nxt_s;
  logic [31:0]      rd_s;

  // Per-bit tri-state drive; input bits float so the outside world can drive them
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = data_dir_r[i] ? data_out_r[i] : 1'bz;
  end

  // Write strobe decode and data truncation to the port width
  always_comb begin
    wr_en_s = avs.chipselect & ~avs.write_n;
    wd_s    = avs.writedata[WIDTH-1:0];
  end

  // Write-1-to-clear mask, only active for a write to EDGECAP
  always_comb begin
    clr_s = {WIDTH{1'b0}};
    if (wr_en_s && (avs.address == ADDR_EDGECAP)) begin
      clr_s = wd_s;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Edge detect from the synchronised sample and its previous value
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      32'sd0:  edge_s = sync2_r & ~last_r;
      32'sd1:  edge_s = ~sync2_r & last_r;
      default: edge_s = sync2_r ^ last_r;
    endcase
  end

  // Next data_out: plain write, plus atomic set/clear when the bit-set feature is built
  always_comb begin
    data_out_nxt_s = data_out_r;
    if (wr_en_s) begin
      case (avs.address)
        ADDR_DATA:   data_out_nxt_s = wd_s;
`ifdef GPIO_PIO_BITSET_EN
        ADDR_OUTSET: data_out_nxt_s = data_out_r | wd_s;
        ADDR_OUTCLR: data_out_nxt_s = data_out_r & ~wd_s;
`endif
        default:     data_out_nxt_s = data_out_r;
      endcase
    end else begin
      data_out_nxt_s = data_out_r;
    end
  end

  // Next direction and mask registers
  always_comb begin
    data_dir_nxt_s = data_dir_r;
    irq_mask_nxt_s = irq_mask_r;
    if (wr_en_s) begin
      case (avs.address)
        ADDR_DIR:     data_dir_nxt_s = wd_s;
        ADDR_IRQMASK: irq_mask_nxt_s = wd_s;
        default: begin
          data_dir_nxt_s = data_dir_r;
          irq_mask_nxt_s = irq_mask_r;
        end
      endcase
    end else begin
      data_dir_nxt_s = data_dir_r;
      irq_mask_nxt_s = irq_mask_r;
    end
  end

  // Edge capture: the set term is ORed last so a coincident edge beats the clear
  always_comb begin
    edge_cap_nxt_s = (edge_cap_r & ~clr_s) | edge_s;
  end

  // Read mux; unused upper bits and unmapped addresses read as zero
  always_comb begin
    rd_s = 32'd0;
    case (avs.address)
      ADDR_DATA:    rd_s[WIDTH-1:0] = sync2_r;
      ADDR_DIR:     rd_s[WIDTH-1:0] = data_dir_r;
      ADDR_IRQMASK: rd_s[WIDTH-1:0] = irq_mask_r;
      ADDR_EDGECAP: rd_s[WIDTH-1:0] = edge_cap_r;
`ifdef GPIO_PIO_BITSET_EN
      ADDR_OUTSET:  rd_s[WIDTH-1:0] = data_out_r;
      ADDR_OUTCLR:  rd_s[WIDTH-1:0] = data_out_r;
`endif
      default:      rd_s = 32'd0;
    endcase
  end

  // Control registers: data_out, data_dir, irq_mask
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_r <= RESET_OUT;
      data_dir_r <= RESET_DIR;
      irq_mask_r <= {WIDTH{1'b0}};
    end else begin
      data_out_r <= data_out_nxt_s;
      data_dir_r <= data_dir_nxt_s;
      irq_mask_r <= irq_mask_nxt_s;
    end
  end

  // Pin synchroniser and edge history; pins are sampled whatever their direction
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      last_r  <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= bidir_port;
      sync2_r <= sync1_r;
      last_r  <= sync2_r;
    end
  end

  // Edge capture register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_cap_r <= {WIDTH{1'b0}};
    end else begin
      edge_cap_r <= edge_cap_nxt_s;
    end
  end

  // Registered read data and interrupt; irq follows the current capture/mask registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      readdata_r <= rd_s;
      irq_r      <= |(edge_cap_r & irq_mask_r);
    end
  end

  assign avs.readdata = readdata_r;
  assign avs.irq      = irq_r;

endmodule
